// File: rtl/opb_register_simulink2ppc_capture_pkg.sv
// Shared definitions for the fabric-to-PowerPC capture register and its OPB ack FSM.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package opb_register_simulink2ppc_capture_pkg;

  // Word offsets inside the block's address window (byte offset bits [3:2])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_RSVD2  = 2'd2;
  localparam logic [1:0] REG_RSVD3  = 2'd3;

  // STATUS word layout
  localparam int NEW_BIT = 0;
  localparam int OVR_LSB = 16;
  localparam int OVR_W   = 16;

  // Overrun counter saturates here rather than wrapping
  localparam logic [OVR_W-1:0] OVR_MAX = 16'hFFFF;

  // One OPB transfer per select assertion: ack once, then wait for select to drop
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } ack_state_t;

  // Assemble the STATUS word from the new-data flag and the overrun count
  function automatic logic [31:0] status_word(input logic new_flag,
                                              input logic [OVR_W-1:0] ovr);
    logic [31:0] w;
    w                    = '0;
    w[NEW_BIT]           = new_flag;
    w[OVR_LSB +: OVR_W]  = ovr;
    return w;
  endfunction

  // Overrun counter update: a STATUS clear restarts the count (an overrun on the
  // same edge counts as the first one); otherwise increment with saturation.
  function automatic logic [OVR_W-1:0] ovr_next(input logic [OVR_W-1:0] ovr,
                                                input logic inc,
                                                input logic clr);
    logic [OVR_W-1:0] n;
    if (clr) begin
      n = inc ? {{(OVR_W-1){1'b0}}, 1'b1} : '0;
    end else if (inc && (ovr != OVR_MAX)) begin
      n = ovr + 1'b1;
    end else begin
      n = ovr;
    end
    return n;
  endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave address decode plus the IDLE/ACK/WAIT handshake, reusable by any OPB register slave.
// Latency: xfer_ack asserts the cycle after the hit cycle and lasts exactly one cycle.
// Backpressure: none; after the ack the FSM parks in WAIT until the master drops select.
module opb_slave_ack_fsm
  import opb_register_simulink2ppc_capture_pkg::*;
#(
  parameter int unsigned                C_OPB_AWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0]    C_BASEADDR   = 32'h01180C00,
  parameter logic [C_OPB_AWIDTH-1:0]    C_HIGHADDR   = 32'h01180CFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [0:C_OPB_AWIDTH-1] abus,
  input  logic                  select,
  input  logic                  rnw,
  output logic                  hit,
  output logic [1:0]            hit_offset,
  output logic                  xfer_ack,
  output logic                  ack_rnw,
  output logic [1:0]            ack_offset,
  output ack_state_t            state
);

  logic [C_OPB_AWIDTH-1:0] addr;
  logic [C_OPB_AWIDTH-1:0] rel;
  logic                    in_window;
  logic                    unused_rel_bits;

  // OPB numbers bit 0 as MSB; a packed copy into a descending vector keeps the numeric value
  assign addr      = abus;
  assign in_window = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign rel       = addr - C_BASEADDR;
  assign hit_offset = rel[3:2];
  assign unused_rel_bits = ^{rel[C_OPB_AWIDTH-1:4], rel[1:0]};

  // A new transfer is only accepted from IDLE, so a held select cannot re-trigger
  assign hit = select && in_window && (state == IDLE);

  // Handshake FSM with registered ack and latched transfer attributes
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      xfer_ack   <= 1'b0;
      ack_rnw    <= 1'b0;
      ack_offset <= REG_DATA;
    end else begin
      case (state)
        IDLE: begin
          xfer_ack <= 1'b0;
          if (hit) begin
            state      <= ACK;
            xfer_ack   <= 1'b1;
            ack_rnw    <= rnw;
            ack_offset <= hit_offset;
          end
        end
        ACK: begin
          xfer_ack <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          xfer_ack <= 1'b0;
          if (!select) begin
            state <= IDLE;
          end
        end
        default: begin
          xfer_ack <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/opb_register_simulink2ppc_capture.sv
// OPB read-back register capturing a fabric word, with sticky new flag and saturating overrun count.
// Latency: capture visible 1 cycle after user_valid; OPB ack/data 1 cycle after the address hit.
// Backpressure: fabric is never stalled; user_pending mirrors the new flag so fabric may throttle itself.
module opb_register_simulink2ppc_capture
  import opb_register_simulink2ppc_capture_pkg::*;
#(
  parameter int unsigned             C_OPB_AWIDTH = 32,
  parameter int unsigned             C_OPB_DWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h01180C00,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h01180CFF,
  parameter string                   C_FAMILY     = "virtex6"
) (
  input  logic                     OPB_Clk,
  input  logic                     OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]  OPB_ABus,
  input  logic [0:3]               OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]  OPB_DBus,
  input  logic                     OPB_RNW,
  input  logic                     OPB_select,
  input  logic                     OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]  Sl_DBus,
  output logic                     Sl_xferAck,
  output logic                     Sl_errAck,
  output logic                     Sl_retry,
  output logic                     Sl_toutSup,
  input  logic [31:0]              user_data_in,
  input  logic                     user_valid,
  output logic                     user_pending
);

  logic             hit;
  logic [1:0]       hit_offset;
  logic             ack_rnw;
  logic [1:0]       ack_offset;
  ack_state_t       fsm_state;

  logic [31:0]      shadow_q;
  logic             new_q;
  logic [OVR_W-1:0] ovr_q;
  logic             be_any_q;

  logic             data_rd_clr;
  logic             status_wr_clr;
  logic             ovr_inc;
  logic [31:0]      rd_word;
  logic             unused_inputs;

  // Nothing in this block is writable with data; writes only act as strobes
  assign unused_inputs = ^{OPB_DBus, OPB_seqAddr, fsm_state};

  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  opb_slave_ack_fsm #(
    .C_OPB_AWIDTH (C_OPB_AWIDTH),
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR)
  ) u_fsm (
    .clk        (OPB_Clk),
    .rst        (OPB_Rst),
    .abus       (OPB_ABus),
    .select     (OPB_select),
    .rnw        (OPB_RNW),
    .hit        (hit),
    .hit_offset (hit_offset),
    .xfer_ack   (Sl_xferAck),
    .ack_rnw    (ack_rnw),
    .ack_offset (ack_offset),
    .state      (fsm_state)
  );

  // Side effects of a transfer land on the ack edge
  assign data_rd_clr   = Sl_xferAck && ack_rnw && (ack_offset == REG_DATA);
  assign status_wr_clr = Sl_xferAck && !ack_rnw && (ack_offset == REG_STATUS) && be_any_q;

  // A capture on top of unread data is an overrun, unless the read clears it on this very edge
  assign ovr_inc = user_valid && new_q && !data_rd_clr;

  // Read mux, evaluated on the hit cycle so the response reflects pre-edge state
  always_comb begin
    rd_word = '0;
    case (hit_offset)
      REG_DATA:   rd_word = shadow_q;
      REG_STATUS: rd_word = status_word(new_q, ovr_q);
      default:    rd_word = '0;
    endcase
  end

  // Registered read data: driven only during the ack cycle, zero otherwise
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      Sl_DBus <= '0;
    end else if (hit && OPB_RNW) begin
      Sl_DBus <= rd_word;
    end else begin
      Sl_DBus <= '0;
    end
  end

  // Remember whether the write carried any byte enable, for use on the ack edge
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      be_any_q <= 1'b0;
    end else if (hit) begin
      be_any_q <= |OPB_BE;
    end
  end

  // Shadow capture and sticky new flag; a capture beats a simultaneous DATA-read clear
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      shadow_q <= '0;
      new_q    <= 1'b0;
    end else begin
      if (user_valid) begin
        shadow_q <= user_data_in;
        new_q    <= 1'b1;
      end else if (data_rd_clr) begin
        new_q    <= 1'b0;
      end
    end
  end

  // Saturating overrun counter, cleared by a byte-enabled STATUS write
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_next(ovr_q, ovr_inc, status_wr_clr);
    end
  end

  assign user_pending = new_q;

endmodule

// File: tb/tb_opb_register_simulink2ppc_capture.sv
module tb_opb_register_simulink2ppc_capture;

  localparam logic [31:0] BASE   = 32'h01180C00;
  localparam logic [31:0] HIGH   = 32'h01180CFF;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_RSV2 = BASE + 32'h8;
  localparam logic [31:0] A_RSV3 = BASE + 32'hC;

  logic        clk;
  logic        OPB_Rst;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic [31:0] user_data_in;
  logic        user_valid;
  logic        user_pending;

  int checks = 0;
  int errors = 0;

  opb_register_simulink2ppc_capture dut (
    .OPB_Clk      (clk),
    .OPB_Rst      (OPB_Rst),
    .OPB_ABus     (OPB_ABus),
    .OPB_BE       (OPB_BE),
    .OPB_DBus     (OPB_DBus),
    .OPB_RNW      (OPB_RNW),
    .OPB_select   (OPB_select),
    .OPB_seqAddr  (OPB_seqAddr),
    .Sl_DBus      (Sl_DBus),
    .Sl_xferAck   (Sl_xferAck),
    .Sl_errAck    (Sl_errAck),
    .Sl_retry     (Sl_retry),
    .Sl_toutSup   (Sl_toutSup),
    .user_data_in (user_data_in),
    .user_valid   (user_valid),
    .user_pending (user_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One OPB transfer; optionally strobes a capture so it lands on the ack edge.
  // lat = cycles from select to ack, -1 if no ack within the budget.
  task automatic opb_xfer(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                          input logic cap, input logic [31:0] cap_dat,
                          output logic [31:0] rdat, output int lat);
    @(negedge clk);
    OPB_ABus   = addr;
    OPB_RNW    = rnw;
    OPB_BE     = be;
    OPB_DBus   = 32'hA5A5_0F0F;
    OPB_select = 1'b1;
    lat  = -1;
    rdat = '0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (Sl_xferAck) begin
        lat  = i;
        rdat = Sl_DBus;
        break;
      end
    end
    @(negedge clk);
    OPB_select = 1'b0;
    if (cap && lat > 0) begin
      user_data_in = cap_dat;
      user_valid   = 1'b1;
    end
    @(negedge clk);
    user_valid = 1'b0;
    OPB_BE     = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] rdat, output int lat);
    opb_xfer(addr, 1'b1, 4'b1111, 1'b0, 32'h0, rdat, lat);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] be, output int lat);
    logic [31:0] dummy;
    opb_xfer(addr, 1'b0, be, 1'b0, 32'h0, dummy, lat);
  endtask

  task automatic capture(input logic [31:0] d);
    @(negedge clk);
    user_data_in = d;
    user_valid   = 1'b1;
    @(negedge clk);
    user_valid   = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    int lat;
    checks++;
    if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'h0 || user_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b dbus=%h pending=%b, need 0/00000000/0", Sl_xferAck, Sl_DBus, user_pending);
    end
    checks++;
    if ({Sl_errAck, Sl_retry, Sl_toutSup} !== 3'b000) begin
      errors++;
      $display("FAIL tieoffs: got %b need 000", {Sl_errAck, Sl_retry, Sl_toutSup});
    end
    rd(A_STAT, r, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL reset_status_latency: got %0d need 1", lat); end
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_status: got %h need 00000000", r); end
    rd(A_DATA, r, lat);
    checks++;
    if (r !== 32'h0 || lat !== 1) begin errors++; $display("FAIL reset_data: got %h lat %0d need 00000000 lat 1", r, lat); end
  endtask

  task automatic test_capture_read;
    logic [31:0] r;
    int lat;
    capture(32'hDEADBEEF);
    checks++;
    if (user_pending !== 1'b1) begin errors++; $display("FAIL pending_set: got %b need 1", user_pending); end
    rd(A_DATA, r, lat);
    checks++;
    if (r !== 32'hDEADBEEF || lat !== 1) begin errors++; $display("FAIL data_read: got %h lat %0d need deadbeef lat 1", r, lat); end
    checks++;
    if (r[31] !== 1'b1) begin errors++; $display("FAIL dbus0_is_msb: got %b need 1", r[31]); end
    checks++;
    if (user_pending !== 1'b0) begin errors++; $display("FAIL pending_clear: got %b need 0", user_pending); end
    rd(A_STAT, r, lat);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL status_after_read: got %h need 00000000", r); end
  endtask

  task automatic test_overrun_clear;
    logic [31:0] r;
    int lat;
    capture(32'h1);
    capture(32'h2);
    capture(32'h3);
    rd(A_STAT, r, lat);
    checks++;
    if (r !== 32'h00020001) begin errors++; $display("FAIL status_two_overruns: got %h need 00020001", r); end
    wr(A_STAT, 4'b0001, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL status_write_ack: got %0d need 1", lat); end
    rd(A_STAT, r, lat);
    checks++;
    if (r !== 32'h00000001) begin errors++; $display("FAIL status_after_clear: got %h need 00000001", r); end
    rd(A_DATA, r, lat);
    checks++;
    if (r !== 32'h3) begin errors++; $display("FAIL data_last_capture: got %h need 00000003", r); end
    rd(A_STAT, r, lat);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL status_empty: got %h need 00000000", r); end
  endtask

  task automatic test_clear_coincident;
    logic [31:0] r;
    logic [31:0] dummy;
    int lat;
    capture(32'h77);
    capture(32'h78);
    // overrun on the same edge as the clear leaves the counter at 1
    opb_xfer(A_STAT, 1'b0, 4'b0100, 1'b1, 32'h79, dummy, lat);
    rd(A_STAT, r, lat);
    checks++;
    if (r !== 32'h00010001) begin errors++; $display("FAIL clear_with_overrun: got %h need 00010001", r); end
    wr(A_STAT, 4'b0000, lat);
    rd(A_STAT, r, lat);
    checks++;
    if (r !== 32'h00010001) begin errors++; $display("FAIL clear_no_be: got %h need 00010001", r); end
    rd(A_DATA, r, lat);
    checks++;
    if (r !== 32'h79) begin errors++; $display("FAIL data_after_coincident: got %h need 00000079", r); end
    wr(A_STAT, 4'b1000, lat);
    rd(A_STAT, r, lat);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL clear_be3: got %h need 00000000", r); end
  endtask

  task automatic test_read_capture_collision;
    logic [31:0] r;
    int lat;
    capture(32'h44);
    opb_xfer(A_DATA, 1'b1, 4'b1111, 1'b1, 32'h55, r, lat);
    checks++;
    if (r !== 32'h44) begin errors++; $display("FAIL collision_read: got %h need 00000044", r); end
    checks++;
    if (user_pending !== 1'b1) begin errors++; $display("FAIL collision_new: got %b need 1", user_pending); end
    rd(A_STAT, r, lat);
    checks++;
    if (r !== 32'h00000001) begin errors++; $display("FAIL collision_status: got %h need 00000001", r); end
    rd(A_DATA, r, lat);
    checks++;
    if (r !== 32'h55) begin errors++; $display("FAIL collision_shadow: got %h need 00000055", r); end
  endtask

  task automatic test_writes_ignored;
    logic [31:0] r;
    int lat;
    wr(A_DATA, 4'b1111, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL data_write_ack: got %0d need 1", lat); end
    rd(A_DATA, r, lat);
    checks++;
    if (r !== 32'h55) begin errors++; $display("FAIL data_write_ignored: got %h need 00000055", r); end
    rd(A_RSV2, r, lat);
    checks++;
    if (r !== 32'h0 || lat !== 1) begin errors++; $display("FAIL rsvd2_read: got %h lat %0d need 0 lat 1", r, lat); end
    wr(A_RSV3, 4'b1111, lat);
    rd(A_RSV3, r, lat);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL rsvd3_read: got %h need 00000000", r); end
  endtask

  task automatic test_select_held;
    int acks;
    acks = 0;
    @(negedge clk);
    OPB_ABus = A_STAT; OPB_RNW = 1'b1; OPB_select = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (Sl_xferAck) acks++;
    end
    @(negedge clk);
    OPB_select = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (acks !== 1) begin errors++; $display("FAIL held_select_acks: got %0d need 1", acks); end
  endtask

  task automatic test_no_hit;
    logic [31:0] r;
    int lat;
    rd(HIGH + 32'h4, r, lat);
    checks++;
    if (lat !== -1) begin errors++; $display("FAIL above_window: got lat %0d need no ack", lat); end
    wr(BASE - 32'h4, 4'b1111, lat);
    checks++;
    if (lat !== -1) begin errors++; $display("FAIL below_window: got lat %0d need no ack", lat); end
    rd(HIGH, r, lat);
    checks++;
    if (lat !== 1 || r !== 32'h0) begin errors++; $display("FAIL high_edge: got %h lat %0d need 0 lat 1", r, lat); end
  endtask

  task automatic test_saturation;
    logic [31:0] r;
    int lat;
    @(negedge clk);
    user_data_in = 32'hCAFE0000;
    user_valid   = 1'b1;
    repeat (70000) @(negedge clk);
    user_valid = 1'b0;
    rd(A_STAT, r, lat);
    checks++;
    if (r !== 32'hFFFF0001) begin errors++; $display("FAIL overrun_saturate: got %h need ffff0001", r); end
    capture(32'hCAFE0001);
    rd(A_STAT, r, lat);
    checks++;
    if (r !== 32'hFFFF0001) begin errors++; $display("FAIL overrun_no_wrap: got %h need ffff0001", r); end
  endtask

  task automatic test_reset_mid_ack;
    logic [31:0] r;
    int lat;
    @(negedge clk);
    OPB_ABus = A_STAT; OPB_RNW = 1'b1; OPB_select = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (Sl_xferAck !== 1'b1) begin errors++; $display("FAIL pre_reset_ack: got %b need 1", Sl_xferAck); end
    OPB_Rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'h0) begin
      errors++; $display("FAIL reset_drops_ack: ack=%b dbus=%h need 0/00000000", Sl_xferAck, Sl_DBus);
    end
    OPB_Rst = 1'b0;
    // select still high: only an FSM back in IDLE acks again
    @(posedge clk);
    #1;
    checks++;
    if (Sl_xferAck !== 1'b1 || Sl_DBus !== 32'h0) begin
      errors++; $display("FAIL reset_to_idle: ack=%b dbus=%h need 1/00000000", Sl_xferAck, Sl_DBus);
    end
    @(negedge clk);
    OPB_select = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rd(A_DATA, r, lat);
    checks++;
    if (r !== 32'h0 || user_pending !== 1'b0) begin
      errors++; $display("FAIL reset_clears_state: data=%h pending=%b need 0/0", r, user_pending);
    end
  endtask

  initial begin
    OPB_Rst      = 1'b1;
    OPB_ABus     = '0;
    OPB_BE       = '0;
    OPB_DBus     = '0;
    OPB_RNW      = 1'b1;
    OPB_select   = 1'b0;
    OPB_seqAddr  = 1'b0;
    user_data_in = '0;
    user_valid   = 1'b0;
    repeat (3) @(negedge clk);
    OPB_Rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_capture_read;
    test_overrun_clear;
    test_clear_coincident;
    test_read_capture_collision;
    test_writes_ignored;
    test_select_held;
    test_no_hit;
    test_saturation;
    test_reset_mid_ack;
    checks++;
    if ({Sl_errAck, Sl_retry, Sl_toutSup} !== 3'b000) begin
      errors++;
      $display("FAIL tieoffs_end: got %b need 000", {Sl_errAck, Sl_retry, Sl_toutSup});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/opb_register_simulink2ppc_capture.md
Name: opb_register_simulink2ppc_capture

Overview:
- OPB slave register for the fabric-to-PowerPC direction. Fabric logic presents a 32-bit word with a valid strobe; the block captures it into a shadow register, and software reads it over OPB.
- A sticky new-data flag and a saturating overrun counter let software detect missed or stale samples.
- Sits on the same OPB bus as the ppc2simulink control registers (e.g. DDS shift); one instance per monitored fabric value.

Parameters:
C_BASEADDR, 32'h01180C00, first byte address of the block's window
C_HIGHADDR, 32'h01180CFF, last byte address of the window
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width
C_FAMILY, "virtex6", target family (informational)

Ports:
OPB_Clk  in  1  sole clock; fabric user logic also runs on this clock
OPB_Rst  in  1  synchronous, active-high reset
OPB_ABus  in  [0:31]  address, bit 0 = MSB
OPB_BE  in  [0:3]  byte enables (ignored except as noted)
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1 = read, 0 = write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data, zero when not acking
Sl_xferAck  out  1  one-cycle transfer acknowledge
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
user_data_in  in  [31:0]  fabric word to capture
user_valid  in  1  capture strobe
user_pending  out  1  mirror of the new-data flag, for fabric throttling

Behaviour:
- Reset is synchronous and active-high: clock OPB_Clk, reset OPB_Rst, no other clock.
- Reset values: shadow=0, new=0, overrun_cnt=0, Sl_DBus=0, Sl_xferAck=0, user_pending=0, FSM=IDLE.
- Reset mid-transfer drops the ack immediately and returns the FSM to IDLE.
- Address hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. The register is selected by offset = (OPB_ABus - C_BASEADDR)[3:2] (LSB numbering):
  - 0 = DATA (RO)
  - 1 = STATUS
  - 2, 3 = reserved, read 0, writes ignored.
- Bit mapping: Sl_DBus[i] = word[31-i], and likewise for OPB_DBus.
- STATUS word: [0] = new; [31:16] = overrun_cnt; all other bits 0.
- FSM (one transfer per select assertion):
  - IDLE -> ACK on hit.
  - ACK: Sl_xferAck=1 for exactly one cycle; on a read, Sl_DBus carries the selected register value sampled on the hit cycle. -> WAIT.
  - WAIT: stays until OPB_select=0, then -> IDLE. No second ack while select stays high.
  - Registered response: ack appears the cycle after the hit (latency 1).
- Capture: user_valid=1 at edge k loads shadow<=user_data_in and new<=1, visible at k+1.
  - If new was already 1 and not being cleared at that edge, overrun_cnt increments, saturating at 0xFFFF (no wrap).
- Read of DATA (the ack cycle of an RNW=1, offset 0 transfer) clears new.
  - Simultaneous capture and DATA-read clear: capture wins; new stays 1, no overrun counted; the read returns the pre-capture shadow.
- Write to STATUS with any OPB_BE bit set clears overrun_cnt at the ack edge.
  - If an overrun increment coincides with that edge, the result is 1.
- Writes to DATA are acknowledged and ignored.
- Non-hit addresses: no ack, no state change.
- user_pending = new.

Decomposition:
- Shared package holds: register offsets (REG_DATA=0, REG_STATUS=1), STATUS bit positions (NEW_BIT=0, OVR_LSB=16), OVR_MAX=16'hFFFF, FSM state typedef {IDLE, ACK, WAIT}.
- One natural sub-module, opb_slave_ack_fsm: address decode plus the IDLE/ACK/WAIT handshake. It outputs a hit-strobe, rnw and offset to the register core, so it is reusable with other OPB slave registers.

Test Plan:
- Reset then STATUS read -> Sl_xferAck one cycle after select; Sl_DBus=0x00000000; Sl_errAck/retry/toutSup=0 throughout.
- user_valid with 0xDEADBEEF, then DATA read -> Sl_DBus=0xDEADBEEF (Sl_DBus[0]=1); subsequent STATUS read = 0x00000000 (new cleared); user_pending 1 then 0.
- Three captures (0x1, 0x2, 0x3) with no read -> DATA=0x3, STATUS=0x00020001; write STATUS with BE=4'b0001 -> STATUS=0x00000001.
- Hold new=1 and strobe user_valid 70000 times -> overrun field stays at 0xFFFF and does not wrap.
- DATA-read ack edge coincident with a capture of 0x55 (prior shadow 0x44) -> read returns 0x44; new=1; overrun unchanged.
- Select held high for 5 cycles -> exactly one ack. Address C_HIGHADDR+4 -> no ack. OPB_Rst asserted during ACK -> Sl_xferAck=0 next cycle and FSM in IDLE.
